seq_alu_monitor: RTL and testbench
==================================

SEQ_ALU_MONITOR -- requirements
Module: seq_alu_monitor

Interface
REQ-001 Parameter WIDTH, default 4, operand width of A and B.
REQ-002 Parameter N_TXN, default 1000, number of enabled transactions that completes a test run.
REQ-003 Parameter CNT_W, default 16, width of the transaction and error counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  ALU enable as driven to the DUT.
REQ-007 A  input  WIDTH  ALU operand A as driven to the DUT.
REQ-008 B  input  WIDTH  ALU operand B as driven to the DUT.
REQ-009 opcode  input  3  ALU operation select as driven to the DUT.
REQ-010 alu_out  input  2*WIDTH  DUT registered result.
REQ-011 mismatch  output  1  one-cycle pulse per compare failure.
REQ-012 txn_cnt  output  CNT_W  checked enabled transactions, saturating.
REQ-013 err_cnt  output  CNT_W  failed compares, saturating.
REQ-014 first_err_opcode  output  3  opcode of the first failing transaction.
REQ-015 done  output  1  run complete, sticky.
REQ-016 pass  output  1  valid when done; 1 means err_cnt==0.

Function
REQ-017 Reference model: exp_q (2*WIDTH) updates on rising edge only when en=1; holds when en=0.
REQ-018 Model opcodes, operands zero-extended: 000 A+B; 001 A-B mod 2^(2*WIDTH); 010 A*B; 011 A&B; 100 A|B; 101 A^B; 110 ~(A&B) in low WIDTH bits, upper bits 0; 111 reserved, result 0.
REQ-019 Latency: a transaction presented with en=1 before edge k is compared at edge k+1 against alu_out, i.e. one cycle, matching the DUT.
REQ-020 Pending flag chk_q is set at each edge with en=1 and cleared at each edge with en=0; a compare occurs only at an edge where chk_q=1.
REQ-021 FSM states IDLE, RUN, DONE; reset to IDLE.
REQ-022 IDLE -> RUN on the first edge with en=1; no compares occur in IDLE.
REQ-023 RUN: each compare increments txn_cnt; alu_out!=exp_q increments err_cnt and pulses mismatch the following cycle.
REQ-024 RUN -> DONE on the compare that brings txn_cnt to N_TXN; that compare is counted.
REQ-025 DONE: counters, first_err_opcode, and pass freeze; done=1; mismatch stays 0; exits only by reset.
REQ-026 first_err_opcode captures the opcode of the transaction behind the first mismatch only; later mismatches leave it unchanged.
REQ-027 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-028 pass = done & (err_cnt==0); pass=0 while done=0.
REQ-029 Back-to-back en=1: one compare per cycle, no bubbles; the en=1 then en=0 pattern compares the last transaction once, then stops.

Reset
REQ-030 rst=0 asynchronously clears exp_q, chk_q, txn_cnt, err_cnt, first_err_opcode, mismatch, done, pass, and forces IDLE.
REQ-031 Reset mid-RUN or in DONE discards all state; the transaction in flight is not compared.
REQ-032 After rst rises, the first compare occurs no earlier than the second rising edge, consistent with DUT output=0 in reset.

Verification
REQ-033 Reset held 2 cycles, then en=1, A=3, B=5, opcode=000, DUT alu_out=8 next cycle -> txn_cnt=1, err_cnt=0, mismatch never asserted.
REQ-034 A=4'hF, B=4'hF, opcode=010, DUT returns 8'hE1 -> pass; DUT returns 8'hE0 -> mismatch pulse, err_cnt=1, first_err_opcode=3'b010.
REQ-035 A=2, B=5, opcode=001 -> exp 8'hFD; opcode=111 -> exp 0; opcode=110 with A=B=4'hF -> exp 8'h00.
REQ-036 en=0 for 10 cycles with random A/B/opcode after a valid transaction -> txn_cnt unchanged, no mismatch, alu_out hold accepted.
REQ-037 N_TXN=1000 random enabled transactions against a correct model -> done=1 and pass=1 at the 1000th compare; further stimulus leaves txn_cnt=1000.
REQ-038 rst pulsed low mid-RUN at txn_cnt=37 with err_cnt=2 -> all outputs 0 immediately, state IDLE, no spurious mismatch after release.

Source files
------------

// File: rtl/seq_alu_monitor.sv
// seq_alu_monitor
// Passive checker for a registered ALU. A one-cycle-latency reference model
// tracks every enabled transaction, compares it against the DUT result one
// edge later, and accumulates saturating transaction and error counts until
// N_TXN compares have been made. At that point the run is done and a pass
// verdict is held until reset.

module seq_alu_monitor #(
  parameter int WIDTH = 4,
  parameter int N_TXN = 1000,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           opcode,
  input  logic [2*WIDTH-1:0]   alu_out,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     txn_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [2:0]           first_err_opcode,
  output logic                 done,
  output logic                 pass
);

  localparam int RW = 2 * WIDTH;

  // Counter ceiling, and the count at which the run is complete.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] N_TXN_C = CNT_W'(N_TXN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_NAND = 3'b110,
    OP_RSVD = 3'b111
  } op_t;

  // Reference ALU: operands zero-extended to the full result width.
  function automatic logic [RW-1:0] alu_model(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [RW-1:0] a_z;
    logic [RW-1:0] b_z;
    logic [RW-1:0] res;
    a_z = {{WIDTH{1'b0}}, a};
    b_z = {{WIDTH{1'b0}}, b};
    res = '0;
    case (op_t'(op))
      OP_ADD:  res = a_z + b_z;
      OP_SUB:  res = a_z - b_z;          // wraps modulo 2^RW
      OP_MUL:  res = a_z * b_z;          // full product fits in RW bits
      OP_AND:  res = a_z & b_z;
      OP_OR:   res = a_z | b_z;
      OP_XOR:  res = a_z ^ b_z;
      OP_NAND: res = {{WIDTH{1'b0}}, ~(a & b)};
      default: res = '0;                 // reserved opcode
    endcase
    return res;
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [RW-1:0]    exp_q;     // expected result of the transaction in flight
  logic [2:0]       op_q;      // opcode of the transaction in flight
  logic             chk_q;     // a transaction is in flight and due for compare

  logic             compare;
  logic             fail;
  logic             last_cmp;
  logic [CNT_W-1:0] txn_inc;

  // Compare qualification: only in RUN, only when a transaction is pending.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing branch would otherwise infer a latch.
    compare  = 1'b0;
    fail     = 1'b0;
    last_cmp = 1'b0;
    txn_inc  = txn_cnt;
    if (state_q == S_RUN && chk_q) begin
      compare  = 1'b1;
      fail     = (alu_out != exp_q);
      txn_inc  = (txn_cnt == CNT_MAX) ? txn_cnt : txn_cnt + 1'b1;
      last_cmp = (txn_inc == N_TXN_C);
    end
  end

  // Reference model pipeline: capture expected result and opcode on enabled edges.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      exp_q <= '0;
      op_q  <= '0;
      chk_q <= 1'b0;
    end else begin
      chk_q <= en;
      if (en) begin
        exp_q <= alu_model(A, B, opcode);
        op_q  <= opcode;
      end
    end
  end

  // Scoreboard counters, first-failure capture and the mismatch pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_cnt          <= '0;
      err_cnt          <= '0;
      first_err_opcode <= '0;
      mismatch         <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (compare) begin
        txn_cnt <= txn_inc;
        if (fail) begin
          if (err_cnt == '0) begin
            first_err_opcode <= op_q;
          end
          if (err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + 1'b1;
          end
          // The completing compare lands in DONE, where mismatch is held low;
          // its error is still reflected in err_cnt and pass.
          mismatch <= ~last_cmp;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: IDLE waits for traffic, RUN ends on the N_TXN-th compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en)       state_d = S_RUN;
      S_RUN:   if (last_cmp) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: done is sticky via the DONE state; pass only qualifies done.
  always_comb begin
    done = (state_q == S_DONE);
    pass = done && (err_cnt == '0);
  end

endmodule

// File: tb/tb_seq_alu_monitor.sv
// Testbench for seq_alu_monitor. The bench plays the role of the registered
// ALU under test (alu_out follows the response chosen per transaction), pushes
// the expected monitor state for every compare into a queue, and a separate
// monitor process pops and checks whenever the monitor shows a compare.
`timescale 1ns/1ps

module tb_seq_alu_monitor;

  localparam int WIDTH = 4;
  localparam int N_TXN = 1000;
  localparam int CNT_W = 16;
  localparam int SAT   = 65535;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [2:0]        opcode;
  logic [7:0]        alu_out;
  logic              mismatch;
  logic [CNT_W-1:0]  txn_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [2:0]        first_err_opcode;
  logic              done;
  logic              pass;

  logic [7:0]        resp;    // value the stand-in ALU registers for this txn

  always #5 clk = ~clk;

  seq_alu_monitor #(.WIDTH(WIDTH), .N_TXN(N_TXN), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .A                (A),
    .B                (B),
    .opcode           (opcode),
    .alu_out          (alu_out),
    .mismatch         (mismatch),
    .txn_cnt          (txn_cnt),
    .err_cnt          (err_cnt),
    .first_err_opcode (first_err_opcode),
    .done             (done),
    .pass             (pass)
  );

  // Stand-in for the ALU: registered result, cleared in reset, held when idle.
  always @(posedge clk or negedge rst) begin
    if (!rst)    alu_out <= 8'h00;
    else if (en) alu_out <= resp;
  end

  typedef struct {
    bit mis;
    int txn;
    int err;
    int first;
    bit done;
    bit pass;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    m_txn, m_err, m_first;
  bit    m_done;
  logic [CNT_W-1:0] prev_txn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Correct ALU behaviour, used to produce good responses for random traffic.
  function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    logic [7:0] x;
    logic [7:0] y;
    x = {4'h0, a};
    y = {4'h0, b};
    case (op)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x * y;
      3'd3:    return x & y;
      3'd4:    return x | y;
      3'd5:    return x ^ y;
      3'd6:    return {4'h0, ~(a & b)};
      default: return 8'h00;
    endcase
  endfunction

  task automatic drive(input bit e, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [7:0] r);
    en = e; A = a; B = b; opcode = op; resp = r;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                     input logic [7:0] r, input bit bad, input bit push = 1'b1);
    snap_t s;
    drive(1'b1, a, b, op, r);
    if (push && !m_done) begin
      if (m_txn < SAT) m_txn++;
      if (bad) begin
        if (m_err == 0) m_first = int'(op);
        if (m_err < SAT) m_err++;
      end
      m_done = (m_txn == N_TXN);
      s = '{mis: bad && !m_done, txn: m_txn, err: m_err, first: m_first,
            done: m_done, pass: m_done && (m_err == 0)};
      exp_q.push_back(s);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 4'($urandom), 4'($urandom), 3'($urandom), 8'($urandom));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mismatch"}, mismatch, 0);
    check({tag, "_txn_cnt"}, txn_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_first_op"}, first_err_opcode, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
  endtask

  // Monitor: every compare moves txn_cnt (or raises mismatch); pop and compare.
  always @(negedge clk) begin
    snap_t s;
    if (!rst) begin
      prev_txn = '0;
    end else if (txn_cnt != prev_txn || mismatch) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: txn_cnt=%0d mismatch=%0d with nothing expected (t=%0t)",
                 txn_cnt, mismatch, $time);
      end else begin
        s = exp_q.pop_front();
        check("sb_mismatch", mismatch, s.mis);
        check("sb_txn_cnt", txn_cnt, s.txn);
        check("sb_err_cnt", err_cnt, s.err);
        check("sb_first_op", first_err_opcode, s.first);
        check("sb_done", done, s.done);
        check("sb_pass", pass, s.pass);
      end
      prev_txn = txn_cnt;
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra, rb;
    logic [2:0] rop;
    rst = 1'b0; en = 1'b0; A = '0; B = '0; opcode = '0; resp = '0;
    m_txn = 0; m_err = 0; m_first = 0; m_done = 1'b0;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // First transaction: compared one edge after it is taken, not before.
    txn(4'd3, 4'd5, 3'b000, 8'h08, 1'b0);
    check("latency_pre", txn_cnt, 0);
    idle(1);
    check("latency_post", txn_cnt, 1);
    check("first_no_mismatch", mismatch, 0);

    // Directed vectors with hand-computed responses.
    txn(4'hF, 4'hF, 3'b010, 8'hE1, 1'b0);
    txn(4'hF, 4'hF, 3'b010, 8'hE0, 1'b1);
    txn(4'd2, 4'd5, 3'b001, 8'hFD, 1'b0);
    check("mismatch_pulse", mismatch, 1);
    check("first_op_captured", first_err_opcode, 3'b010);
    txn(4'd2, 4'd5, 3'b111, 8'h00, 1'b0);
    check("mismatch_one_cycle", mismatch, 0);
    txn(4'hF, 4'hF, 3'b110, 8'h00, 1'b0);
    txn(4'h9, 4'h6, 3'b100, 8'h0F, 1'b0);
    txn(4'hC, 4'hA, 3'b101, 8'h06, 1'b0);
    txn(4'hC, 4'hA, 3'b011, 8'h08, 1'b0);
    txn(4'd2, 4'd5, 3'b001, 8'hFE, 1'b1);

    // Ten idle cycles with random inputs: no compares, result hold accepted.
    idle(10);
    wait_drain("drain_directed");
    check("hold_txn_cnt", txn_cnt, 10);
    check("hold_err_cnt", err_cnt, 2);
    check("first_op_kept", first_err_opcode, 3'b010);

    // Bring the run to 37 transactions with 2 errors, then reset mid-flight.
    for (int i = 0; i < 27; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rop = 3'($urandom);
      txn(ra, rb, rop, golden(ra, rb, rop), 1'b0);
    end
    idle(2);
    wait_drain("drain_pre_reset");
    check("pre_reset_txn_cnt", txn_cnt, 37);
    check("pre_reset_err_cnt", err_cnt, 2);
    txn(4'd1, 4'd1, 3'b000, 8'hFF, 1'b1, 1'b0);   // in flight, must not be compared
    rst = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    m_txn = 0; m_err = 0; m_first = 0; m_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(5);
    check("post_reset_txn_cnt", txn_cnt, 0);
    check("post_reset_mismatch", mismatch, 0);
    check("post_reset_done", done, 0);

    // Full run: N_TXN back-to-back good transactions.
    for (int i = 0; i < N_TXN; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rop = 3'($urandom);
      txn(ra, rb, rop, golden(ra, rb, rop), 1'b0);
    end
    check("done_not_early", done, 0);
    idle(1);
    check("run_done", done, 1);
    check("run_pass", pass, 1);
    check("run_txn_cnt", txn_cnt, N_TXN);

    // Further traffic, including bad responses, leaves DONE frozen.
    for (int i = 0; i < 20; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rop = 3'($urandom);
      txn(ra, rb, rop, golden(ra, rb, rop) ^ 8'h01, 1'b1);
    end
    idle(2);
    check("frozen_txn_cnt", txn_cnt, N_TXN);
    check("frozen_err_cnt", err_cnt, 0);
    check("frozen_done", done, 1);
    check("frozen_pass", pass, 1);
    check("frozen_mismatch", mismatch, 0);
    wait_drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
